// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Unsigned magnitude; the most-negative value maps onto itself.
  function automatic logic [DIV_WIDTH-1:0] abs_u(input logic [DIV_WIDTH-1:0] value);
    return value[DIV_WIDTH-1] ? (~value + 1'b1) : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The partial remainder stays below the divisor, so its top bit is always 0.
  // Using the full shifted value keeps the WIDTH+1-bit trial subtract exact.
  always_comb begin
    shifted  = {rem, dvd_msb};
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_iter.sv
// Multicycle signed divider, one quotient bit per clock (restoring algorithm).
// Define DIV_REMAINDER_EN to add the signed data_remainder output.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY,
  output logic             data_exception,
`ifdef DIV_REMAINDER_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic             busy
);

  // Handshake: ctrl_DIV is a single-cycle start sampled with the operands on the
  // same edge; data_resultRDY is a single-cycle strobe qualifying data_result and
  // data_exception. A new start at any time abandons the operation in flight.

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] divisor;
  logic             sign_q;
  logic             divzero;
`ifdef DIV_REMAINDER_EN
  logic             sign_r;
`endif

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd_msb  (dvd[WIDTH-1]),
    .divisor  (divisor),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      count          <= '0;
      rem            <= '0;
      dvd            <= '0;
      q              <= '0;
      divisor        <= '0;
      sign_q         <= 1'b0;
      divzero        <= 1'b0;
      data_result    <= '0;
      data_resultRDY <= 1'b0;
      data_exception <= 1'b0;
      busy           <= 1'b0;
`ifdef DIV_REMAINDER_EN
      sign_r         <= 1'b0;
      data_remainder <= '0;
`endif
    end else begin
      data_resultRDY <= 1'b0;
      data_exception <= 1'b0;
      if (ctrl_DIV) begin
        dvd     <= abs_u(data_operandA);
        divisor <= abs_u(data_operandB);
        sign_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        divzero <= (data_operandB == '0);
        count   <= '0;
        rem     <= '0;
        q       <= '0;
        busy    <= 1'b1;
        state   <= (data_operandB == '0) ? DONE : RUN;
`ifdef DIV_REMAINDER_EN
        sign_r  <= data_operandA[WIDTH-1];
`endif
      end else begin
        case (state)
          RUN: begin
            rem   <= step_rem;
            dvd   <= dvd << 1;
            q     <= {q[WIDTH-2:0], step_q};
            count <= count + 1'b1;
            if (count == LAST) state <= DONE;
          end
          DONE: begin
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
            state          <= IDLE;
            if (divzero) begin
              data_result    <= '0;
              data_exception <= 1'b1;
`ifdef DIV_REMAINDER_EN
              data_remainder <= '0;
`endif
            end else begin
              data_result    <= sign_q ? -q : q;
`ifdef DIV_REMAINDER_EN
              data_remainder <= sign_r ? -rem : rem;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed and random checks for div_iter: latency, sign handling, divide-by-zero, abort, reset.
module tb_div_iter;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         ctrl_DIV;
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic [W-1:0] data_result;
  logic         data_resultRDY;
  logic         data_exception;
  logic         busy;
`ifdef DIV_REMAINDER_EN
  logic [W-1:0] data_remainder;
`endif

  int errors = 0;
  int checks = 0;

  div_iter dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception),
`ifdef DIV_REMAINDER_EN
    .data_remainder (data_remainder),
`endif
    .busy           (busy)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_exc;
    int           exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver: one-cycle start pulse, returns at the falling edge after the sampling edge
  task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    @(negedge clock);
    ctrl_DIV      = 1'b0;
  endtask

  // counts falling edges after the sampling edge until the strobe, bounded
  task automatic wait_rdy(output int lat);
    lat = 0;
    while (!data_resultRDY && lat < 60) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    start_div(v.a, v.b);
    wait_rdy(lat);
    check({name, "_latency"}, W'(lat), W'(v.exp_lat));
    check({name, "_result"}, data_result, v.exp_q);
    check({name, "_exception"}, W'(data_exception), W'(v.exp_exc));
`ifdef DIV_REMAINDER_EN
    check({name, "_remainder"}, data_remainder, v.exp_r);
`endif
    @(negedge clock);
    check({name, "_strobe_drop"}, W'(data_resultRDY), W'(0));
    check({name, "_hold"}, data_result, v.exp_q);
  endtask

  initial begin
    int lat;
    int strobes;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;

    vecs.push_back('{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33});
    vecs.push_back('{-32'sd100,      32'd7,          -32'sd14,       -32'sd2,        1'b0, 33});
    vecs.push_back('{32'd100,        -32'sd7,        -32'sd14,       32'd2,          1'b0, 33});
    vecs.push_back('{-32'sd100,      -32'sd7,        32'd14,         -32'sd2,        1'b0, 33});
    vecs.push_back('{32'd5,          32'd0,          32'd0,          32'd0,          1'b1, 1});
    vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 33});
    vecs.push_back('{32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0, 33});
    vecs.push_back('{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 33});
    vecs.push_back('{32'd7,          32'd100,        32'd0,          32'd7,          1'b0, 33});
    vecs.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 33});
    vecs.push_back('{32'h7FFF_FFFF,  32'd2,          32'h3FFF_FFFF,  32'd1,          1'b0, 33});
    vecs.push_back('{32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0,          1'b0, 33});
    vecs.push_back('{-32'sd7,        32'd2,          -32'sd3,        -32'sd1,        1'b0, 33});
    vecs.push_back('{32'h8000_0000,  32'd0,          32'd0,          32'd0,          1'b1, 1});

    reset = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    check("reset_result", data_result, '0);
    check("reset_rdy", W'(data_resultRDY), W'(0));
    check("reset_exception", W'(data_exception), W'(0));
    check("reset_busy", W'(busy), W'(0));
    reset = 1'b1;
    @(negedge clock);

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // busy spans the run and drops with the strobe
    start_div(32'd50, 32'd5);
    check("busy_running", W'(busy), W'(1));
    wait_rdy(lat);
    check("busy_at_strobe", W'(busy), W'(0));
    check("busy_result", data_result, 32'd10);

    // abort: restart 10 cycles into a run, only the second result strobes
    start_div(32'd100, 32'd7);
    repeat (8) @(negedge clock);
    start_div(32'd81, 32'd9);
    wait_rdy(lat);
    check("abort_latency", W'(lat), W'(33));
    check("abort_result", data_result, 32'd9);
    strobes = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) strobes++;
    end
    check("abort_single_strobe", W'(strobes), W'(0));

    // reset mid-run: outputs clear at once, nothing strobes afterwards
    start_div(32'd100, 32'd7);
    repeat (13) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("midreset_result", data_result, '0);
    check("midreset_busy", W'(busy), W'(0));
    reset = 1'b1;
    strobes = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY || busy) strobes++;
    end
    check("midreset_no_strobe", W'(strobes), W'(0));

    // random signed pairs against the simulator's signed division
    for (int i = 0; i < 20; i++) begin
      vec_t v;
      sa = $urandom;
      sb = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(1, 300));
      if ($urandom_range(0, 1) == 1) sb = -sb;
      if (sb == 0) sb = 3;
      if (sa == 32'sh8000_0000 && sb == -1) sb = 5;
      v.a = sa;
      v.b = sb;
      v.exp_q = sa / sb;
      v.exp_r = sa % sb;
      v.exp_exc = 1'b0;
      v.exp_lat = 33;
      run_vec($sformatf("rand%0d", i), v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
